// File: rtl/fir_stream_ctrl.sv
// Streaming controller for an external FIR filter: replays a sample buffer into the
// filter at a programmable rate and captures one filter result per issued sample.
module fir_stream_ctrl #(
   parameter  int N     = 16,
   parameter  int DEPTH = 32,
   parameter  int LAT   = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [N-1:0]  wr_data_i,
   input  logic          start_i,
   input  logic [AW:0]   len_i,
   input  logic [7:0]    rate_i,
   output logic [N-1:0]  filt_in_o,
   output logic          filt_clr_o,
   input  logic [N-1:0]  filt_out_i,
   output logic [N-1:0]  out_data_o,
   output logic          out_valid_o,
   output logic          busy_o,
   output logic          done_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    mem_q [DEPTH];
   logic [AW:0]     len_q, len_d;
   logic [7:0]      rate_q, rate_d;
   logic [7:0]      wait_q, wait_d;
   logic [AW:0]     iss_q, iss_d;
   logic [AW:0]     res_q, res_d;
   logic [LAT-1:0]  strb_q, strb_d;
   logic [N-1:0]    filt_in_q, filt_in_d;
   logic            filt_clr_q, filt_clr_d;
   logic [N-1:0]    out_data_q, out_data_d;
   logic            out_valid_q, out_valid_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            launch_s;
   logic            issue_s;
   logic            last_iss_s;
   logic            emerge_s;
   logic            last_res_s;
   logic [AW:0]     len_eff_s;

   // A run is clear-then-feed; the first sample goes out on the edge that leaves CLEAR.
   assign launch_s   = (state_q == S_IDLE) && start_i;
   assign issue_s    = (state_q == S_CLEAR) || ((state_q == S_FEED) && (wait_q == 8'd0));
   assign last_iss_s = issue_s && (iss_q == (len_q - (AW+1)'(1)));
   assign emerge_s   = strb_q[LAT-1] && ((state_q == S_FEED) || (state_q == S_DRAIN));
   assign last_res_s = emerge_s && (res_q == (len_q - (AW+1)'(1)));
   assign len_eff_s  = ((len_i == '0) || (len_i > (AW+1)'(DEPTH))) ? (AW+1)'(DEPTH) : len_i;

   // Sample buffer: no reset, writable only while idle.
   always_ff @(posedge clk_i) begin
      if (wr_en_i && !busy_q) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; the final result takes priority over a pending issue.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = start_i ? S_CLEAR : S_IDLE;
         S_CLEAR: state_d = last_iss_s ? S_DRAIN : S_FEED;
         S_FEED: begin
            if (last_res_s) begin
               state_d = S_DONE;
            end else if (last_iss_s) begin
               state_d = S_DRAIN;
            end else begin
               state_d = S_FEED;
            end
         end
         S_DRAIN: state_d = last_res_s ? S_DONE : S_DRAIN;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      len_d       = len_q;
      rate_d      = rate_q;
      wait_d      = wait_q;
      iss_d       = iss_q;
      res_d       = res_q;
      strb_d      = LAT'({strb_q, issue_s});
      filt_in_d   = '0;
      out_data_d  = out_data_q;
      out_valid_d = emerge_s;
      filt_clr_d  = (state_d == S_CLEAR);
      busy_d      = (state_d != S_IDLE) || (state_q != S_IDLE);
      done_d      = (state_q == S_DONE);
      if (launch_s) begin
         len_d  = len_eff_s;
         rate_d = rate_i;
         wait_d = 8'd0;
         iss_d  = '0;
         res_d  = '0;
         strb_d = '0;
      end else begin
         if (issue_s) begin
            wait_d = rate_q;
            iss_d  = iss_q + (AW+1)'(1);
         end else if (state_q == S_FEED) begin
            wait_d = wait_q - 8'd1;
         end else begin
            wait_d = wait_q;
         end
         if (emerge_s) begin
            res_d = res_q + (AW+1)'(1);
         end else begin
            res_d = res_q;
         end
      end
      if (issue_s) begin
         filt_in_d = mem_q[iss_q[AW-1:0]];
      end else if (state_q == S_FEED) begin
         filt_in_d = filt_in_q;
      end else begin
         filt_in_d = '0;
      end
      if (emerge_s) begin
         out_data_d = filt_out_i;
      end else begin
         out_data_d = out_data_q;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         len_q       <= '0;
         rate_q      <= 8'd0;
         wait_q      <= 8'd0;
         iss_q       <= '0;
         res_q       <= '0;
         strb_q      <= '0;
         filt_in_q   <= '0;
         filt_clr_q  <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         len_q       <= len_d;
         rate_q      <= rate_d;
         wait_q      <= wait_d;
         iss_q       <= iss_d;
         res_q       <= res_d;
         strb_q      <= strb_d;
         filt_in_q   <= filt_in_d;
         filt_clr_q  <= filt_clr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign filt_in_o   = filt_in_q;
   assign filt_clr_o  = filt_clr_q;
   assign out_data_o  = out_data_q;
   assign out_valid_o = out_valid_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed bench for fir_stream_ctrl: a run table plus reset-abort and idle checks,
// with a small delay-line filter model in front of filt_out.
module tb_fir_stream_ctrl;

   localparam int N     = 16;
   localparam int DEPTH = 32;
   localparam int LAT   = 4;
   localparam int AW    = 5;
   localparam logic [N-1:0] FKEY = 16'h5A00;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          wr_en_i;
   logic [AW-1:0] wr_addr_i;
   logic [N-1:0]  wr_data_i;
   logic          start_i;
   logic [AW:0]   len_i;
   logic [7:0]    rate_i;
   logic [N-1:0]  filt_in_o;
   logic          filt_clr_o;
   logic [N-1:0]  filt_out_i;
   logic [N-1:0]  out_data_o;
   logic          out_valid_o;
   logic          busy_o;
   logic          done_o;

   logic [N-1:0]  d1, d2, d3;
   logic [N-1:0]  model_mem [DEPTH];
   int            total = 0;
   int            bad   = 0;

   typedef struct {
      int ln;
      int rt;
      int cnt;
      int gap;
      int done_e;
      bit fill;
      bit pk_start;
      bit pk_wr;
   } vec_t;

   vec_t vecs [8];

   fir_stream_ctrl #(.N(N), .DEPTH(DEPTH), .LAT(LAT)) dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .wr_en_i    (wr_en_i),
      .wr_addr_i  (wr_addr_i),
      .wr_data_i  (wr_data_i),
      .start_i    (start_i),
      .len_i      (len_i),
      .rate_i     (rate_i),
      .filt_in_o  (filt_in_o),
      .filt_clr_o (filt_clr_o),
      .filt_out_i (filt_out_i),
      .out_data_o (out_data_o),
      .out_valid_o(out_valid_o),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   always #5 clk_i = ~clk_i;

   // Filter model: LAT-1 register stages so the result for a sample is ready LAT cycles later.
   always @(posedge clk_i) begin
      d1 <= filt_in_o;
      d2 <= d1;
      d3 <= d2;
   end
   assign filt_out_i = d3 ^ FKEY;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic write_mem(input int addr, input logic [N-1:0] data);
      wr_en_i   = 1'b1;
      wr_addr_i = AW'(addr);
      wr_data_i = data;
      @(posedge clk_i);
      #1;
      wr_en_i = 1'b0;
      model_mem[addr] = data;
   endtask

   task automatic run(input vec_t v);
      int edge_n;
      int vcnt;
      int dcnt;
      int last_v;
      int done_at;
      int busy_low_at;
      start_i = 1'b1;
      len_i   = (AW+1)'(v.ln);
      rate_i  = 8'(v.rt);
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      chk("clr_after_e0", int'(filt_clr_o), 1);
      chk("busy_after_e0", int'(busy_o), 1);
      edge_n = 0; vcnt = 0; dcnt = 0; last_v = -1; done_at = -1; busy_low_at = -1;
      while (busy_low_at < 0 && edge_n < 400) begin
         start_i = (v.pk_start && edge_n >= 3 && edge_n <= 5) ? 1'b1 : 1'b0;
         if (v.pk_wr && edge_n == 2) begin
            wr_en_i   = 1'b1;
            wr_addr_i = '0;
            wr_data_i = 16'hFFFF;
         end else begin
            wr_en_i = 1'b0;
         end
         @(posedge clk_i);
         #1;
         edge_n++;
         if (edge_n == 1) begin
            chk("clr_after_e1", int'(filt_clr_o), 0);
            chk("first_sample", int'(filt_in_o), int'(model_mem[0]));
         end
         if (v.cnt > 1 && edge_n == 1 + v.rt + 1) begin
            chk("second_sample", int'(filt_in_o), int'(model_mem[1]));
         end
         if (out_valid_o) begin
            if (vcnt < DEPTH) begin
               chk("out_data", int'(out_data_o), int'(model_mem[vcnt] ^ FKEY));
            end
            if (vcnt == 0) begin
               chk("first_valid_edge", edge_n, 5);
            end else begin
               chk("valid_gap", edge_n - last_v, v.gap);
            end
            last_v = edge_n;
            vcnt++;
         end
         if (done_o) begin
            dcnt++;
            done_at = edge_n;
         end
         if (!busy_o) begin
            busy_low_at = edge_n;
         end
      end
      start_i = 1'b0;
      wr_en_i = 1'b0;
      chk("result_count", vcnt, v.cnt);
      chk("done_count", dcnt, 1);
      chk("done_edge", done_at, v.done_e);
      chk("busy_low_edge", busy_low_at, v.done_e + 1);
      chk("filt_in_idle", int'(filt_in_o), 0);
      repeat (2) @(posedge clk_i);
      #1;
   endtask

   initial begin
      vecs[0] = '{ln: 4,  rt: 0, cnt: 4,  gap: 1, done_e: 9,  fill: 1'b0, pk_start: 1'b0, pk_wr: 1'b0};
      vecs[1] = '{ln: 2,  rt: 3, cnt: 2,  gap: 4, done_e: 10, fill: 1'b0, pk_start: 1'b0, pk_wr: 1'b0};
      vecs[2] = '{ln: 0,  rt: 0, cnt: 32, gap: 1, done_e: 37, fill: 1'b1, pk_start: 1'b0, pk_wr: 1'b0};
      vecs[3] = '{ln: 1,  rt: 5, cnt: 1,  gap: 0, done_e: 6,  fill: 1'b0, pk_start: 1'b0, pk_wr: 1'b0};
      vecs[4] = '{ln: 40, rt: 0, cnt: 32, gap: 1, done_e: 37, fill: 1'b0, pk_start: 1'b0, pk_wr: 1'b0};
      vecs[5] = '{ln: 3,  rt: 1, cnt: 3,  gap: 2, done_e: 10, fill: 1'b0, pk_start: 1'b1, pk_wr: 1'b0};
      vecs[6] = '{ln: 4,  rt: 0, cnt: 4,  gap: 1, done_e: 9,  fill: 1'b0, pk_start: 1'b0, pk_wr: 1'b1};
      vecs[7] = '{ln: 4,  rt: 0, cnt: 4,  gap: 1, done_e: 9,  fill: 1'b0, pk_start: 1'b0, pk_wr: 1'b0};

      reset_i = 1'b1; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
      start_i = 1'b0; len_i = '0; rate_i = 8'd0;
      repeat (3) @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      chk("rst_filt_in", int'(filt_in_o), 0);
      chk("rst_filt_clr", int'(filt_clr_o), 0);
      chk("rst_out_data", int'(out_data_o), 0);
      chk("rst_out_valid", int'(out_valid_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_done", int'(done_o), 0);

      for (int i = 0; i < DEPTH; i++) begin
         write_mem(i, (i < 4) ? N'(i + 1) : N'(i * 3 + 100));
      end

      for (int t = 0; t < 8; t++) begin
         if (vecs[t].fill) begin
            for (int i = 0; i < DEPTH; i++) begin
               write_mem(i, N'(i));
            end
         end
         run(vecs[t]);
      end

      // Abort a run with reset two cycles after start.
      for (int i = 0; i < 4; i++) begin
         write_mem(i, N'(16'h0010 + i));
      end
      start_i = 1'b1; len_i = 6'd4; rate_i = 8'd0;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      @(posedge clk_i);
      #1;
      reset_i = 1'b1;
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      chk("abort_filt_in", int'(filt_in_o), 0);
      chk("abort_filt_clr", int'(filt_clr_o), 0);
      chk("abort_out_valid", int'(out_valid_o), 0);
      chk("abort_busy", int'(busy_o), 0);
      chk("abort_done", int'(done_o), 0);
      begin
         int stray;
         stray = 0;
         for (int i = 0; i < 15; i++) begin
            @(posedge clk_i);
            #1;
            if (out_valid_o || done_o || busy_o) stray++;
         end
         chk("abort_quiet", stray, 0);
      end
      run(vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
